main_mem_arbiter: RTL and testbench

//  Shares the single 128-bit main-memory chip between the instruction-cache refill port (P0, read-only)
//  and the data-cache refill/write-back port (P1, read/write). Sequences the chip's CS/OE/WE/Addr/Data/Ready_Mem

---
 rtl/mem_arb_pkg.sv | 19 +
 rtl/rr_arb2.sv | 34 +++
 rtl/main_mem_arbiter.sv | 155 +++++++++++++++
 tb/tb_main_mem_arbiter.sv | 260 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the main-memory arbiter: FSM states, default widths and port ids.
package mem_arb_pkg;

  localparam int DATA_W_DEF  = 128;
  localparam int ADDR_W_DEF  = 25;
  localparam int TMO_CYC_DEF = 15;

  localparam logic P_I = 1'b0;
  localparam logic P_D = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    ISSUE,
    WAIT_BUSY,
    WAIT_READY,
    DONE
  } state_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-input round-robin arbiter; the pointer favours whichever port was not served last.
module rr_arb2
  import mem_arb_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] req,
  input  logic       advance,
  input  logic       served,
  output logic       grant_valid,
  output logic       grant
);

  logic ptr_reg;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ptr_reg <= P_I;
    end else if (advance) begin
      ptr_reg <= ~served;
    end
  end

  // The pointer only matters under contention; a lone requester always wins.
  always_comb begin
    grant_valid = |req;
    if (&req) begin
      grant = ptr_reg;
    end else begin
      grant = req[1] ? P_D : P_I;
    end
  end

endmodule

// File: rtl/main_mem_arbiter.sv
// Shares the main-memory chip between the I-cache and D-cache refill ports: one CS/OE/WE/Ready_Mem
// handshake at a time, round-robin grant, and a busy watchdog that forces completion and sets err.
module main_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int DATA_W  = DATA_W_DEF,
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int TMO_CYC = TMO_CYC_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              p0_req,
  input  logic [ADDR_W-1:0] p0_addr,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic              err,
  output logic              mem_cs,
  output logic              mem_oe,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  inout  wire  [DATA_W-1:0] mem_data,
  input  logic              mem_ready
);

  localparam logic [3:0] TMO_LAST = 4'(TMO_CYC - 1);

  state_t            state_reg, state_next;
  logic              port_reg;
  logic              we_reg;
  logic [ADDR_W-1:0] addr_reg;
  logic [DATA_W-1:0] wdata_reg;
  logic [DATA_W-1:0] line_buf_reg;
  logic [3:0]        tmo_reg;
  logic              timeout;
  logic              wait_state;
  logic              grant_valid;
  logic              grant;

  rr_arb2 u_arb (
    .clk         (clk),
    .reset       (reset),
    .req         ({p1_req, p0_req}),
    .advance     (state_reg == DONE),
    .served      (port_reg),
    .grant_valid (grant_valid),
    .grant       (grant)
  );

  assign mem_data   = mem_we ? wdata_reg : {DATA_W{1'bz}};
  assign wait_state = (state_reg == WAIT_BUSY) || (state_reg == WAIT_READY);

  always_comb begin
    state_next = state_reg;
    timeout    = 1'b0;
    case (state_reg)
      IDLE:       if (grant_valid && mem_ready) state_next = ISSUE;
      ISSUE:      state_next = WAIT_BUSY;
      WAIT_BUSY: begin
        if (!mem_ready) begin
          state_next = WAIT_READY;
        end else if (tmo_reg == TMO_LAST) begin
          state_next = DONE;
          timeout    = 1'b1;
        end
      end
      WAIT_READY: begin
        if (mem_ready) begin
          state_next = DONE;
        end else if (tmo_reg == TMO_LAST) begin
          state_next = DONE;
          timeout    = 1'b1;
        end
      end
      DONE:       state_next = IDLE;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg    <= IDLE;
      port_reg     <= P_I;
      we_reg       <= 1'b0;
      addr_reg     <= '0;
      wdata_reg    <= '0;
      line_buf_reg <= '0;
      tmo_reg      <= '0;
      mem_cs       <= 1'b0;
      mem_oe       <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      p0_ack       <= 1'b0;
      p1_ack       <= 1'b0;
      p0_rdata     <= '0;
      p1_rdata     <= '0;
      err          <= 1'b0;
    end else begin
      state_reg <= state_next;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      if (state_next != state_reg) begin
        tmo_reg <= '0;
      end else if (wait_state) begin
        tmo_reg <= tmo_reg + 4'd1;
      end
      case (state_reg)
        IDLE: begin
          if (state_next == ISSUE) begin
            port_reg  <= grant;
            we_reg    <= (grant == P_D) && p1_we;
            addr_reg  <= (grant == P_D) ? p1_addr : p0_addr;
            wdata_reg <= p1_wdata;
          end
        end
        ISSUE: begin
          mem_cs   <= 1'b1;
          mem_addr <= addr_reg;
          mem_we   <= we_reg;
          mem_oe   <= ~we_reg;
        end
        WAIT_BUSY, WAIT_READY: begin
          // The line buffer keeps the last word seen while the chip reported busy.
          if (!we_reg && !mem_ready) begin
            line_buf_reg <= mem_data;
          end
          if (state_next == DONE) begin
            mem_cs <= 1'b0;
            mem_oe <= 1'b0;
            mem_we <= 1'b0;
            if (port_reg == P_I) begin
              p0_ack   <= 1'b1;
              p0_rdata <= line_buf_reg;
            end else begin
              p1_ack <= 1'b1;
              if (!we_reg) begin
                p1_rdata <= line_buf_reg;
              end
            end
            if (timeout) begin
              err <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_main_mem_arbiter.sv
// Self-checking bench: behavioural memory chip, per-cycle reference checks, directed and random traffic.
module tb_main_mem_arbiter;

  localparam int DW = 128;
  localparam int AW = 25;

  logic          clk = 1'b0;
  logic          reset;
  logic          p0_req, p1_req, p1_we;
  logic [AW-1:0] p0_addr, p1_addr;
  logic [DW-1:0] p1_wdata;
  logic          p0_ack, p1_ack, err;
  logic [DW-1:0] p0_rdata, p1_rdata;
  logic          mem_cs, mem_oe, mem_we, mem_ready;
  logic [AW-1:0] mem_addr;
  wire  [DW-1:0] mem_data;

  int tests_run    = 0;
  int tests_failed = 0;
  int stall_len;
  int ack_log[$];

  always #5 clk = ~clk;

  main_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .p0_req(p0_req), .p0_addr(p0_addr), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_ack(p1_ack), .p1_rdata(p1_rdata), .err(err),
    .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_data(mem_data), .mem_ready(mem_ready)
  );

  function automatic logic [DW-1:0] preload(input int i);
    if (i == 'h10) return {16{8'hA5}};
    return {8{16'(i)}};
  endfunction

  task automatic check(input string name, input logic [DW-1:0] act, input logic [DW-1:0] req);
    tests_run++;
    if (act !== req) begin
      tests_failed++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Memory chip: busy for stall_len cycles (random 1..5 when 0) after each CS, re-armed once CS drops.
  logic [DW-1:0] chip_mem [256];
  logic          chip_ready, chip_armed, chip_we;
  logic [7:0]    chip_addr;
  int            chip_cnt;

  assign mem_ready = chip_ready;
  assign mem_data  = (!chip_ready && !chip_we) ? chip_mem[chip_addr] : {DW{1'bz}};

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      chip_ready <= 1'b1;
      chip_armed <= 1'b1;
      chip_we    <= 1'b0;
      chip_addr  <= '0;
      chip_cnt   <= 0;
      for (int i = 0; i < 256; i++) chip_mem[i] <= preload(i);
    end else if (chip_ready) begin
      if (!mem_cs) begin
        chip_armed <= 1'b1;
      end else if (chip_armed) begin
        chip_ready <= 1'b0;
        chip_armed <= 1'b0;
        chip_addr  <= mem_addr[7:0];
        chip_we    <= mem_we;
        chip_cnt   <= (stall_len > 0) ? stall_len : int'($urandom_range(1, 5));
        if (mem_we) chip_mem[mem_addr[7:0]] <= mem_data;
      end
    end else if (chip_cnt <= 1) begin
      chip_ready <= 1'b1;
    end else begin
      chip_cnt <= chip_cnt - 1;
    end
  end

  // Reference model: memory contents, expected rdata/err, and the round-robin fairness rule.
  logic [DW-1:0] ref_mem [256];
  logic [DW-1:0] exp_p0, exp_p1;
  logic          exp_err, have_prev, prev_port, prev_other_pend, prev_p0_ack, prev_p1_ack, port;

  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (reset) begin
        for (int i = 0; i < 256; i++) ref_mem[i] = preload(i);
        exp_p0 = '0; exp_p1 = '0; exp_err = 1'b0; have_prev = 1'b0;
        prev_p0_ack = 1'b0; prev_p1_ack = 1'b0;
      end else begin
        check("ack_exclusive", p0_ack & p1_ack, 0);
        if (p0_ack || p1_ack) begin
          port = p1_ack;
          check("ack_one_cycle", port ? prev_p1_ack : prev_p0_ack, 0);
          check("ack_has_req", port ? p1_req : p0_req, 1);
          check("ack_cs_low", mem_cs, 0);
          if (have_prev && prev_other_pend) check("rr_order", port, !prev_port);
          ack_log.push_back(int'(port));
          if (!port) exp_p0 = ref_mem[p0_addr[7:0]];
          else if (p1_we) ref_mem[p1_addr[7:0]] = p1_wdata;
          else exp_p1 = ref_mem[p1_addr[7:0]];
          if (stall_len >= 20) exp_err = 1'b1;
          prev_port = port;
          prev_other_pend = port ? p0_req : p1_req;
          have_prev = 1'b1;
        end
        prev_p0_ack = p0_ack;
        prev_p1_ack = p1_ack;
        check("p0_rdata", p0_rdata, exp_p0);
        check("p1_rdata", p1_rdata, exp_p1);
        check("err", err, exp_err);
        if (mem_cs) begin
          check("cs_with_req", p0_req | p1_req, 1);
          check("oe_vs_we", mem_oe, !mem_we);
        end
        if (mem_we) begin
          check("we_is_p1_write", p1_req & p1_we, 1);
          check("we_addr", mem_addr, p1_addr);
          check("we_data", mem_data, p1_wdata);
        end
      end
    end
  end

  task automatic p0_txn(input logic [AW-1:0] a);
    int n;
    @(negedge clk);
    p0_addr = a;
    p0_req  = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!p0_ack && n < 200);
    check("p0_ack_seen", p0_ack, 1);
    check("p0_latency_ge5", n >= 5, 1);
    $display("[TB] p0 read  addr=%0h cycles=%0d rdata=%0h", a, n, p0_rdata);
    p0_req = 1'b0;
  endtask

  task automatic p1_txn(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    @(negedge clk);
    p1_we    = we;
    p1_addr  = a;
    p1_wdata = d;
    p1_req   = 1'b1;
    n = 0;
    do begin @(negedge clk); n++; end while (!p1_ack && n < 200);
    check("p1_ack_seen", p1_ack, 1);
    check("p1_latency_ge5", n >= 5, 1);
    $display("[TB] p1 %s addr=%0h cycles=%0d data=%0h", we ? "write" : "read ", a, n, we ? d : p1_rdata);
    p1_req = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    int n;
    int exp_order [6] = '{0, 1, 0, 1, 0, 1};
    reset = 1'b1; p0_req = 1'b0; p0_addr = '0; p1_req = 1'b0; p1_we = 1'b0;
    p1_addr = '0; p1_wdata = '0; stall_len = 0;
    repeat (3) @(negedge clk);
    check("rst_cs", mem_cs, 0);
    check("rst_oe", mem_oe, 0);
    check("rst_we", mem_we, 0);
    check("rst_addr", mem_addr, 0);
    check("rst_acks", {p0_ack, p1_ack}, 0);
    check("rst_p0_rdata", p0_rdata, 0);
    check("rst_p1_rdata", p1_rdata, 0);
    check("rst_err", err, 0);
    reset = 1'b0;

    p0_txn(25'h10);
    check("t1_rdata", p0_rdata, {16{8'hA5}});

    p1_txn(1'b1, 25'h20, 128'h0123);
    p0_txn(25'h20);
    check("t2_rdata", p0_rdata, 128'h0123);

    do_reset();
    ack_log.delete();
    for (int r = 0; r < 3; r++) begin
      fork
        p0_txn(25'($urandom_range(0, 63)));
        p1_txn(1'b0, 25'($urandom_range(0, 63)), '0);
      join
    end
    check("t3_count", ack_log.size(), 6);
    for (int i = 0; i < 6 && i < ack_log.size(); i++) check("t3_grant", ack_log[i], exp_order[i]);

    stall_len = 20;
    p0_txn(25'h21);
    check("t4_err", err, 1);
    check("t4_mem_still_busy", mem_ready, 0);
    check("t4_rdata", p0_rdata, {8{16'h0021}});
    n = 0;
    while (!mem_ready && n < 50) begin @(negedge clk); n++; end
    check("t4_mem_recovers", mem_ready, 1);
    stall_len = 0;
    p1_txn(1'b0, 25'h22, '0);
    check("t4_next_ok", p1_rdata, {8{16'h0022}});

    stall_len = 10;
    @(negedge clk);
    p0_addr = 25'h30;
    p0_req  = 1'b1;
    n = 0;
    while (!(mem_cs && !mem_ready) && n < 50) begin @(negedge clk); n++; end
    check("t5_reached_wait", mem_cs && !mem_ready, 1);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_cs", mem_cs, 0);
    check("t5_oe", mem_oe, 0);
    check("t5_we", mem_we, 0);
    check("t5_ack", p0_ack, 0);
    p0_req = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
    stall_len = 0;
    p0_txn(25'h10);
    check("t5_after", p0_rdata, {16{8'hA5}});

    p1_txn(1'b0, 25'h1, '0);
    check("t6_rd1", p1_rdata, {8{16'h0001}});
    p1_txn(1'b0, 25'h2, '0);
    check("t6_rd2", p1_rdata, {8{16'h0002}});

    fork
      for (int k = 0; k < 15; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        p0_txn(25'($urandom_range(0, 63)));
      end
      for (int k = 0; k < 15; k++) begin
        repeat ($urandom_range(0, 3)) @(negedge clk);
        p1_txn(1'($urandom_range(0, 1)), 25'($urandom_range(0, 63)),
               {$urandom, $urandom, $urandom, $urandom});
      end
    join

    repeat (5) @(negedge clk);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
